pe_io_sequencer: RTL
====================

# pe_io_sequencer

Initiator-side driver for a PE wrapper's FIFO interface. Pushes a programmed number of filter, ifmap and ipsum bus words from three valid/ready source streams into the PE's input FIFOs, honouring their full flags, and drains a programmed number of opsum words from the PE's output FIFO into a registered valid/ready sink. Sits between the global-buffer/NoC side and one PE wrapper, one instance per PE.

## Interface
- DATA_WIDTH_IFMAP, 16: ifmap bus word width.
- DATA_WIDTH_FILTER, 64: filter bus word width.
- DATA_WIDTH_PSUM, 64: ipsum/opsum bus word width.
- CNT_WIDTH, 16: width of all word counters.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- start  in  1  begin a transfer; sampled only in IDLE.
- num_filter / num_ifmap / num_ipsum / num_opsum  in  CNT_WIDTH each  bus-word counts, latched on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on completion.
- filter_in, ifmap_in, ipsum_in  in  matching bus width  source data.
- filter_in_valid, ifmap_in_valid, ipsum_in_valid  in  1  source valid.
- filter_in_ready, ifmap_in_ready, ipsum_in_ready  out  1  source ready.
- filter, ifmap, ipsum  out  matching bus width  data to PE FIFOs (pass-through of *_in).
- push_filter, push_ifmap, push_ipsum  out  1  PE FIFO write strobes.
- filter_fifo_full, ifmap_fifo_full, ipsum_fifo_full  in  1  PE FIFO full flags.
- opsum  in  DATA_WIDTH_PSUM  PE opsum FIFO head (first-word-fall-through).
- pop_opsum  out  1  PE opsum FIFO read strobe.
- opsum_fifo_empty  in  1  PE opsum FIFO empty.
- opsum_out  out  DATA_WIDTH_PSUM  registered opsum to sink.
- opsum_out_valid  out  1  sink valid.
- opsum_out_ready  in  1  sink ready.

## Operation
- States: IDLE, FILTER, STREAM, DRAIN, DONE.
- IDLE: start=1 latches the four counts into remaining counters; next state FILTER if num_filter!=0, else STREAM. start while busy is ignored.
- FILTER: filter channel active; leave to STREAM when filter counter reaches 0 (including the cycle of the last push).
- STREAM: ifmap and ipsum channels active concurrently, opsum drain active; go to DRAIN when both ifmap and ipsum counters are 0.
- DRAIN: opsum drain only; go to DONE when opsum counter is 0 and opsum_out_valid=0.
- DONE: done=1 for exactly one cycle; next IDLE.
- Push channel X: X_in_ready = active & rem_X!=0 & ~X_fifo_full (never depends on X_in_valid); push_X = X_in_ready & X_in_valid; rem_X decrements by 1 per push; X = X_in combinationally.
- Opsum drain: pop_opsum = (STREAM|DRAIN) & rem_opsum!=0 & ~opsum_fifo_empty & (~opsum_out_valid | opsum_out_ready). On pop: opsum_out <= opsum, opsum_out_valid <= 1, rem_opsum - 1. Sink handshake without pop clears opsum_out_valid.
- Counters never underflow; a zero count makes its channel idle for the whole transfer.

## Timing
- Reset values: busy=0, done=0, all *_in_ready=0, push_*=0, pop_opsum=0, opsum_out_valid=0, opsum_out=0, state IDLE, counters 0. Reset mid-transfer aborts immediately; no done pulse.
- Push latency: 0 cycles (combinational valid/ready to push).
- Opsum latency: FIFO head to opsum_out_valid 1 cycle; full throughput 1 word/cycle with ready held high.
- Start to first filter push: 1 cycle. Last event to done: 1 cycle (via DONE state); done to busy=0: same cycle done drops.
- Full asserted in same cycle as valid: no push, data must be held by source.

## Structure
- Package pe_io_pkg: state enum, CNT_WIDTH default, shared helper for counter-is-zero.
- Sub-module pe_push_channel (parameterised width): remaining counter, ready/push gating; instantiated for filter, ifmap, ipsum.

## Test plan
- Basic: num_filter=4, num_ifmap=6, num_ipsum=2, num_opsum=2, all valid/ready high, FIFOs never full -> exactly 4/6/2 pushes, 2 opsum words out in order, done 1 pulse, busy 0 afterwards.
- Backpressure: filter_fifo_full high cycles 2-5 of FILTER -> no push_filter, filter_in_ready=0 those cycles, total 4 pushes still.
- Sink stall: opsum_out_ready low 3 cycles with 2 words pending -> pop_opsum held 0 while valid pending, no data loss, values 0xA, 0xB delivered in order.
- Zero counts: num_filter=0, num_ipsum=0 -> FILTER skipped, push_filter/push_ipsum never asserted.
- Reset mid-STREAM: reset=0 after 3 ifmap pushes -> all outputs at reset values next edge, no done; new start runs full counts.
- start while busy -> ignored, counts unchanged.

Source files
------------

// File: rtl/pe_io_pkg.sv
// Shared types and helpers for the PE I/O sequencer: FSM state encoding,
// default counter width and the counter-is-zero test used by every channel.
package pe_io_pkg;

    localparam int CNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILTER = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic cnt_is_zero(input logic [CNT_WIDTH_DEF-1:0] cnt);
        return (cnt == {CNT_WIDTH_DEF{1'b0}});
    endfunction

endpackage

// File: rtl/pe_push_channel.sv
// One push channel: remaining-word counter plus ready/push gating from a
// valid/ready source into a PE input FIFO.
import pe_io_pkg::*;

module pe_push_channel #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [CNT_WIDTH_DEF-1:0] load_count,
    input  logic                     active,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [WIDTH-1:0]         data,
    output logic                     push,
    input  logic                     fifo_full,
    output logic                     drained
);

    localparam logic [CNT_WIDTH_DEF-1:0] CNT_ONE = {{(CNT_WIDTH_DEF-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH_DEF-1:0] rem_r;
    logic                     rem_zero_s;

    assign rem_zero_s    = cnt_is_zero(rem_r);
    // Ready is independent of valid so the source may legally wait on it.
    assign data_in_ready = active & ~rem_zero_s & ~fifo_full;
    assign push          = data_in_ready & data_in_valid;
    assign data          = data_in;
    // True already in the cycle of the final push so the FSM can advance then.
    assign drained       = rem_zero_s | (push & (rem_r == CNT_ONE));

    // Remaining-word counter: loaded on an accepted start, decremented per push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_r <= {CNT_WIDTH_DEF{1'b0}};
        end else if (load) begin
            rem_r <= load_count;
        end else if (push) begin
            rem_r <= rem_r - CNT_ONE;
        end else begin
            rem_r <= rem_r;
        end
    end

endmodule

// File: rtl/pe_io_sequencer.sv
// Initiator-side sequencer for one PE wrapper: pushes filter, then ifmap and
// ipsum words into the PE FIFOs while draining opsum words into a registered sink.
import pe_io_pkg::*;

module pe_io_sequencer #(
    parameter int DATA_WIDTH_IFMAP  = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int DATA_WIDTH_PSUM   = 64,
    parameter int CNT_WIDTH         = CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         num_filter,
    input  logic [CNT_WIDTH-1:0]         num_ifmap,
    input  logic [CNT_WIDTH-1:0]         num_ipsum,
    input  logic [CNT_WIDTH-1:0]         num_opsum,
    output logic                         busy,
    output logic                         done,
    input  logic [DATA_WIDTH_FILTER-1:0] filter_in,
    input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_in,
    input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_in,
    input  logic                         filter_in_valid,
    input  logic                         ifmap_in_valid,
    input  logic                         ipsum_in_valid,
    output logic                         filter_in_ready,
    output logic                         ifmap_in_ready,
    output logic                         ipsum_in_ready,
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
    output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
    output logic                         push_filter,
    output logic                         push_ifmap,
    output logic                         push_ipsum,
    input  logic                         filter_fifo_full,
    input  logic                         ifmap_fifo_full,
    input  logic                         ipsum_fifo_full,
    input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
    output logic                         pop_opsum,
    input  logic                         opsum_fifo_empty,
    output logic [DATA_WIDTH_PSUM-1:0]   opsum_out,
    output logic                         opsum_out_valid,
    input  logic                         opsum_out_ready
);

    state_e                       state_r;
    logic [CNT_WIDTH-1:0]         rem_opsum_r;
    logic [DATA_WIDTH_PSUM-1:0]   opsum_out_r;
    logic                         opsum_out_valid_r;
    logic                         load_s;
    logic                         filter_drained_s;
    logic                         ifmap_drained_s;
    logic                         ipsum_drained_s;
    logic                         drain_active_s;

    assign load_s          = (state_r == ST_IDLE) & start;
    assign drain_active_s  = (state_r == ST_STREAM) | (state_r == ST_DRAIN);
    assign busy            = (state_r != ST_IDLE);
    assign done            = (state_r == ST_DONE);
    assign opsum_out       = opsum_out_r;
    assign opsum_out_valid = opsum_out_valid_r;
    // Pop only when the output register is empty or being emptied this cycle.
    assign pop_opsum       = drain_active_s & ~cnt_is_zero(rem_opsum_r) & ~opsum_fifo_empty
                           & (~opsum_out_valid_r | opsum_out_ready);

    pe_push_channel #(.WIDTH(DATA_WIDTH_FILTER)) u_filter (
        .clk(clk), .reset(reset), .load(load_s), .load_count(num_filter),
        .active(state_r == ST_FILTER), .data_in(filter_in), .data_in_valid(filter_in_valid),
        .data_in_ready(filter_in_ready), .data(filter), .push(push_filter),
        .fifo_full(filter_fifo_full), .drained(filter_drained_s)
    );

    pe_push_channel #(.WIDTH(DATA_WIDTH_IFMAP)) u_ifmap (
        .clk(clk), .reset(reset), .load(load_s), .load_count(num_ifmap),
        .active(state_r == ST_STREAM), .data_in(ifmap_in), .data_in_valid(ifmap_in_valid),
        .data_in_ready(ifmap_in_ready), .data(ifmap), .push(push_ifmap),
        .fifo_full(ifmap_fifo_full), .drained(ifmap_drained_s)
    );

    pe_push_channel #(.WIDTH(DATA_WIDTH_PSUM)) u_ipsum (
        .clk(clk), .reset(reset), .load(load_s), .load_count(num_ipsum),
        .active(state_r == ST_STREAM), .data_in(ipsum_in), .data_in_valid(ipsum_in_valid),
        .data_in_ready(ipsum_in_ready), .data(ipsum), .push(push_ipsum),
        .fifo_full(ipsum_fifo_full), .drained(ipsum_drained_s)
    );

    // Transfer FSM together with the opsum counter and registered sink stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r           <= ST_IDLE;
            rem_opsum_r       <= {CNT_WIDTH{1'b0}};
            opsum_out_r       <= {DATA_WIDTH_PSUM{1'b0}};
            opsum_out_valid_r <= 1'b0;
        end else begin
            if (load_s) begin
                rem_opsum_r <= num_opsum;
            end else if (pop_opsum) begin
                rem_opsum_r <= rem_opsum_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                rem_opsum_r <= rem_opsum_r;
            end

            if (pop_opsum) begin
                opsum_out_r       <= opsum;
                opsum_out_valid_r <= 1'b1;
            end else if (opsum_out_valid_r & opsum_out_ready) begin
                opsum_out_valid_r <= 1'b0;
            end else begin
                opsum_out_valid_r <= opsum_out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= cnt_is_zero(num_filter) ? ST_STREAM : ST_FILTER;
                    end
                end
                ST_FILTER: begin
                    if (filter_drained_s) begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (ifmap_drained_s & ipsum_drained_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_is_zero(rem_opsum_r) & ~opsum_out_valid_r) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
